// File: rtl/rk16_pkg.sv
// Shared RK16 fetch-path types and constants.
package rk16_pkg;

   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned FETCH_DEPTH = 4;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [INST_W-1:0] inst_t;

   typedef struct packed {
      addr_t pc;
      inst_t inst;
   } fetch_entry_t;

   localparam addr_t RESET_PC_DEFAULT = ADDR_W'(0);

   // Counter width able to hold the values 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head reads as zero when empty.
module ifetch_fifo
   import rk16_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               wr_entry,
   output fetch_entry_t               head,
   output logic [cnt_w(DEPTH)-1:0]    count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = cnt_w(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign head    = (count != '0) ? mem[rd_ptr] : '0;

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/ifetch.sv
// RK16 instruction fetch: owns the PC, issues in-order memory reads, buffers
// returned words for decode and discards in-flight work on redirect.
module ifetch
   import rk16_pkg::*;
#(
   parameter int unsigned DEPTH    = FETCH_DEPTH,
   parameter addr_t       RESET_PC = RESET_PC_DEFAULT
) (
   input  logic  clk,
   input  logic  rst,
   output logic  imem_req_valid,
   input  logic  imem_req_ready,
   output addr_t imem_req_addr,
   input  logic  imem_rsp_valid,
   input  inst_t imem_rsp_data,
   output logic  id_valid,
   input  logic  id_ready,
   output inst_t id_inst,
   output addr_t id_pc,
   input  logic  redirect,
   input  addr_t redirect_pc
);

   localparam int unsigned CNT_W = cnt_w(DEPTH);

   addr_t            pc;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] drop;
   logic [CNT_W-1:0] occ;
   logic [CNT_W-1:0] aq_count;
   logic [CNT_W:0]   budget;
   logic             accept;
   logic             rsp_keep;
   logic             pop;
   fetch_entry_t     aq_wr;
   fetch_entry_t     aq_head;
   fetch_entry_t     rsp_entry;
   fetch_entry_t     buf_head;

   // Requests in flight plus buffered words never exceed the buffer size,
   // so every response is guaranteed a free slot.
   assign budget         = (CNT_W+1)'(inflight) + (CNT_W+1)'(occ);
   assign imem_req_valid = !rst && !redirect && (budget < (CNT_W+1)'(DEPTH));
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign id_valid = (occ != '0) && !redirect;
   assign pop      = id_valid && id_ready;
   assign id_inst  = buf_head.inst;
   assign id_pc    = buf_head.pc;

   // A response with no queued address cannot be matched to a PC; ignore it.
   assign rsp_keep = imem_rsp_valid && (drop == '0) && !redirect && (aq_count != '0);

   assign aq_wr = '{pc: pc, inst: '0};

   always_comb begin
      rsp_entry      = aq_head;
      rsp_entry.inst = imem_rsp_data;
   end

   ifetch_fifo #(.DEPTH(DEPTH)) u_addr_q (
      .clk      (clk),
      .rst      (rst),
      .push     (accept),
      .pop      (rsp_keep),
      .flush    (redirect),
      .wr_entry (aq_wr),
      .head     (aq_head),
      .count    (aq_count)
   );

   ifetch_fifo #(.DEPTH(DEPTH)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (rsp_keep),
      .pop      (pop),
      .flush    (redirect),
      .wr_entry (rsp_entry),
      .head     (buf_head),
      .count    (occ)
   );

   // On redirect every still-outstanding response becomes one to drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         if (redirect) begin
            pc <= redirect_pc;
         end else if (accept) begin
            pc <= pc + ADDR_W'(1);
         end
         inflight <= inflight + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
         if (redirect) begin
            drop <= inflight - CNT_W'(imem_rsp_valid);
         end else if (imem_rsp_valid && (drop != '0)) begin
            drop <= drop - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a fixed-latency in-order memory model.
module tb_ifetch;
   import rk16_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  imem_req_valid;
   logic  imem_req_ready;
   addr_t imem_req_addr;
   logic  imem_rsp_valid;
   inst_t imem_rsp_data;
   logic  id_valid;
   logic  id_ready;
   inst_t id_inst;
   addr_t id_pc;
   logic  redirect;
   addr_t redirect_pc;

   int passed = 0;
   int total  = 0;
   int mem_lat = 1;
   int cyc = 0;

   typedef struct {
      addr_t addr;
      int    due;
   } mreq_t;
   mreq_t mq[$];

   always #5 clk = ~clk;

   ifetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc)
   );

   // Memory: records accepted requests at the edge, answers mem_lat cycles later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         cyc = 0;
      end else begin
         cyc++;
         if (imem_rsp_valid && mq.size() > 0) mq.delete(0);
         if (imem_req_valid && imem_req_ready)
            mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      end
   end

   always @(negedge clk) begin
      if (rst || mq.size() == 0 || mq[0].due != cyc + 1) begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hA000_0000 + {16'h0000, mq[0].addr};
      end
   end

   // Holds reset for two cycles and releases it on a falling edge.
   task automatic do_reset(input int lat);
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      id_ready = 1'b1;
      imem_req_ready = 1'b1;
      mem_lat = lat;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      id_ready = 1'b1;
      imem_req_ready = 1'b1;
      mem_lat = 1;
      repeat (2) @(negedge clk);
      total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); else passed++;
      total++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b want 0", id_valid); else passed++;
      total++; if (id_inst !== 32'h0) $display("FAIL reset_id_inst: got %h want 0", id_inst); else passed++;
      total++; if (id_pc !== 16'h0) $display("FAIL reset_id_pc: got %h want 0", id_pc); else passed++;
      rst = 1'b0;
      #1;
      total++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", imem_req_valid); else passed++;
      total++; if (imem_req_addr !== 16'h0000) $display("FAIL first_req_addr: got %h want 0000", imem_req_addr); else passed++;
   endtask

   task automatic test_stream;
      addr_t e;
      do_reset(1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) begin
            total++; if (id_valid !== 1'b0) $display("FAIL stream_early_valid: got %b want 0", id_valid); else passed++;
         end else begin
            e = addr_t'(c - 2);
            total++;
            if (id_valid !== 1'b1 || id_pc !== e || id_inst !== 32'hA000_0000 + {16'h0000, e})
               $display("FAIL stream_c%0d: valid=%b pc=%h inst=%h want valid=1 pc=%h inst=%h",
                        c, id_valid, id_pc, id_inst, e, 32'hA000_0000 + {16'h0000, e});
            else passed++;
         end
      end
   endtask

   task automatic test_backpressure;
      addr_t e;
      do_reset(1);
      repeat (2) @(negedge clk);
      total++; if (id_valid !== 1'b1 || id_pc !== 16'h0000) $display("FAIL bp_first: valid=%b pc=%h want 1/0000", id_valid, id_pc); else passed++;
      @(negedge clk);
      total++; if (id_valid !== 1'b1 || id_pc !== 16'h0001) $display("FAIL bp_second: valid=%b pc=%h want 1/0001", id_valid, id_pc); else passed++;
      id_ready = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         total++; if (imem_req_valid !== 1'b0) $display("FAIL bp_full_req: got %b want 0", imem_req_valid); else passed++;
         total++;
         if (id_valid !== 1'b1 || id_pc !== 16'h0001 || id_inst !== 32'hA000_0001)
            $display("FAIL bp_hold: valid=%b pc=%h inst=%h want 1/0001/a0000001", id_valid, id_pc, id_inst);
         else passed++;
      end
      id_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         e = addr_t'(1 + k);
         total++;
         if (id_valid !== 1'b1 || id_pc !== e || id_inst !== 32'hA000_0000 + {16'h0000, e})
            $display("FAIL bp_drain_%0d: valid=%b pc=%h inst=%h want 1/%h", k, id_valid, id_pc, id_inst, e);
         else passed++;
      end
   endtask

   task automatic test_redirect;
      int    first_c;
      addr_t e;
      do_reset(3);
      repeat (3) @(negedge clk);
      total++; if (id_valid !== 1'b0) $display("FAIL redir_pre_valid: got %b want 0", id_valid); else passed++;
      redirect = 1'b1;
      redirect_pc = 16'h0100;
      #1;
      total++; if (imem_req_valid !== 1'b0) $display("FAIL redir_req_gated: got %b want 0", imem_req_valid); else passed++;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0100)
         $display("FAIL redir_req: valid=%b addr=%h want 1/0100", imem_req_valid, imem_req_addr);
      else passed++;
      first_c = -1;
      e = 16'h0100;
      for (int c = 5; c <= 16; c++) begin
         @(negedge clk);
         if (id_valid) begin
            if (first_c < 0) first_c = c;
            total++;
            if (id_pc !== e || id_inst !== 32'hA000_0000 + {16'h0000, e})
               $display("FAIL redir_seq: pc=%h inst=%h want pc=%h", id_pc, id_inst, e);
            else passed++;
            e = e + 16'd1;
         end
      end
      total++; if (first_c != 8) $display("FAIL redir_latency: first valid at cycle %0d want 8", first_c); else passed++;
      total++; if (e < 16'h0105) $display("FAIL redir_count: next pc %h want at least 0105", e); else passed++;
   endtask

   task automatic test_redirect2;
      int    first_c;
      addr_t e;
      do_reset(4);
      repeat (4) @(negedge clk);
      redirect = 1'b1;
      redirect_pc = 16'h0100;
      @(negedge clk);
      redirect = 1'b0;
      total++; if (id_valid !== 1'b0) $display("FAIL redir2_valid_a: got %b want 0", id_valid); else passed++;
      @(negedge clk);
      total++; if (id_valid !== 1'b0) $display("FAIL redir2_valid_b: got %b want 0", id_valid); else passed++;
      redirect = 1'b1;
      redirect_pc = 16'h0200;
      #1;
      total++; if (imem_req_valid !== 1'b0) $display("FAIL redir2_req_gated: got %b want 0", imem_req_valid); else passed++;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0200)
         $display("FAIL redir2_req: valid=%b addr=%h want 1/0200", imem_req_valid, imem_req_addr);
      else passed++;
      first_c = -1;
      e = 16'h0200;
      for (int c = 8; c <= 20; c++) begin
         @(negedge clk);
         if (id_valid) begin
            if (first_c < 0) first_c = c;
            total++;
            if (id_pc !== e || id_pc[15:8] == 8'h01 || id_inst !== 32'hA000_0000 + {16'h0000, e})
               $display("FAIL redir2_seq: pc=%h inst=%h want pc=%h", id_pc, id_inst, e);
            else passed++;
            e = e + 16'd1;
         end
      end
      total++; if (first_c != 12) $display("FAIL redir2_latency: first valid at cycle %0d want 12", first_c); else passed++;
      total++; if (e < 16'h0204) $display("FAIL redir2_count: next pc %h want at least 0204", e); else passed++;
   endtask

   task automatic test_wrap;
      addr_t exp_pc [4];
      exp_pc[0] = 16'hfffe;
      exp_pc[1] = 16'hffff;
      exp_pc[2] = 16'h0000;
      exp_pc[3] = 16'h0001;
      do_reset(1);
      redirect = 1'b1;
      redirect_pc = 16'hfffe;
      @(negedge clk);
      redirect = 1'b0;
      @(negedge clk);
      total++; if (id_valid !== 1'b0) $display("FAIL wrap_early_valid: got %b want 0", id_valid); else passed++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (id_valid !== 1'b1 || id_pc !== exp_pc[i] || id_inst !== 32'hA000_0000 + {16'h0000, exp_pc[i]})
            $display("FAIL wrap_%0d: valid=%b pc=%h inst=%h want 1/%h", i, id_valid, id_pc, id_inst, exp_pc[i]);
         else passed++;
      end
   endtask

   task automatic test_async_reset;
      do_reset(1);
      repeat (5) @(negedge clk);
      total++; if (id_valid !== 1'b1 || id_pc !== 16'h0003) $display("FAIL areset_pre: valid=%b pc=%h want 1/0003", id_valid, id_pc); else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++; if (imem_req_valid !== 1'b0) $display("FAIL areset_req_valid: got %b want 0", imem_req_valid); else passed++;
      total++; if (id_valid !== 1'b0) $display("FAIL areset_id_valid: got %b want 0", id_valid); else passed++;
      total++; if (id_inst !== 32'h0 || id_pc !== 16'h0) $display("FAIL areset_id_data: inst=%h pc=%h want 0/0", id_inst, id_pc); else passed++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000)
         $display("FAIL areset_restart_req: valid=%b addr=%h want 1/0000", imem_req_valid, imem_req_addr);
      else passed++;
      @(negedge clk);
      total++; if (id_valid !== 1'b0) $display("FAIL areset_early_valid: got %b want 0", id_valid); else passed++;
      @(negedge clk);
      total++;
      if (id_valid !== 1'b1 || id_pc !== 16'h0000 || id_inst !== 32'hA000_0000)
         $display("FAIL areset_first: valid=%b pc=%h inst=%h want 1/0000/a0000000", id_valid, id_pc, id_inst);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect2();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
